// File: rtl/prio_enc_queue_pkg.sv
// Shared types and helpers for the priority-encoder request queue.
// clog2, onehot, slot state enum, N_MAX limit.
package prio_enc_pkg;

  localparam int N_MAX     = 64;
  localparam int IDX_MAX_W = 6;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [N_MAX-1:0] onehot(
    input logic [IDX_MAX_W-1:0] idx,
    input int                   n
  );
    logic [N_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < N_MAX; i++)
      r[i] = (i < n) && (int'(idx) == i);
    return r;
  endfunction

endpackage

// File: rtl/prio_enc_queue_if.sv
// Valid/ready output channel carrying a served source index.
// master: drives out_valid/out_idx, samples out_ready; slave: reverse.
interface prio_enc_if #(
  parameter int W = 3
);
  import prio_enc_pkg::*;

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;

  modport master (
    output out_valid,
    output out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_idx,
    output out_ready
  );
endinterface

// File: rtl/prio_enc_queue_find.sv
// Combinational first-set-bit finder: lowest set index of vec.
// Ports: vec (N) in, idx (clog2 N) out, any out (vec non-zero).
module prio_find_first
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = W'(i);
  end

  assign any = |vec;

endmodule

// File: rtl/prio_enc_queue.sv
// Sticky request capture + priority encoder feeding one valid/ready slot.
// Ports: clk, rst (sync high), req_i, dn (master), pend_o, coal_cnt. Macro PRIO_ENC_RR_EN selects round-robin.
module prio_enc_queue
  import prio_enc_pkg::*;
#(
  parameter  int N     = 8,
  parameter  int CNT_W = 16,
  localparam int W     = clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  prio_enc_if.master       dn,
  output logic [N-1:0]     pend_o,
  output logic [CNT_W-1:0] coal_cnt
);

  typedef logic [N-1:0] vec_t;
  localparam int SUM_W = CNT_W + 7;

  slot_t        state, state_nxt;
  logic [W-1:0] idx_q, idx_nxt;
  logic [W-1:0] first_idx;
  vec_t         pend, pend_nxt;
  vec_t         oh, clr, held, cand, coal;
  logic         xfer, load, cand_any;
  logic [6:0]   pop;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt_nxt;

  assign xfer = (state == FULL) && dn.out_ready;
  assign oh   = vec_t'(onehot(IDX_MAX_W'(idx_q), N));
  assign clr  = xfer ? oh : '0;
  // outstanding index may not be offered again until it transfers
  assign held = ((state == FULL) && !xfer) ? oh : '0;
  assign cand = (pend & ~clr & ~held) | req_i;
  assign load = ((state == EMPTY) || dn.out_ready) && cand_any;

  // a fresh request beats the clear on the same bit
  assign pend_nxt = (pend & ~clr) | req_i;
  assign coal     = req_i & pend & ~clr;

`ifdef PRIO_ENC_RR_EN
  logic [W-1:0]   rr_ptr, rr_nxt, start;
  logic [2*N-1:0] mask, wide;
  logic [W:0]     wide_idx;

  assign rr_nxt = (idx_q == W'(N - 1)) ? '0 : idx_q + 1'b1;
  // search start already reflects a transfer in this cycle
  assign start  = xfer ? rr_nxt : rr_ptr;

  always_comb begin
    mask = '0;
    for (int i = 0; i < 2 * N; i++)
      mask[i] = (i >= N) || (i >= int'(start));
  end

  assign wide = {cand, cand} & mask;

  prio_find_first #(.N(2 * N)) u_find (
    .vec (wide),
    .idx (wide_idx),
    .any (cand_any)
  );

  assign first_idx = (wide_idx >= (W+1)'(N))
                   ? W'(wide_idx - (W+1)'(N))
                   : wide_idx[W-1:0];

  always_ff @(posedge clk) begin
    if (rst)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= rr_nxt;
  end
`else
  prio_find_first #(.N(N)) u_find (
    .vec (cand),
    .idx (first_idx),
    .any (cand_any)
  );
`endif

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++)
      pop = pop + 7'(coal[i]);
  end

  assign sum     = SUM_W'(coal_cnt) + SUM_W'(pop);
  assign cnt_nxt = (sum > SUM_W'({CNT_W{1'b1}}))
                 ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx_q;
    if (load) begin
      state_nxt = FULL;
      idx_nxt   = first_idx;
    end else if (xfer) begin
      state_nxt = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      idx_q    <= '0;
      pend     <= '0;
      coal_cnt <= '0;
    end else begin
      state    <= state_nxt;
      idx_q    <= idx_nxt;
      pend     <= pend_nxt;
      coal_cnt <= cnt_nxt;
    end
  end

  assign dn.out_valid = (state == FULL);
  assign dn.out_idx   = idx_q;
  assign pend_o       = pend;

endmodule

// File: tb/tb_prio_enc_queue.sv
// Directed bench for prio_enc_queue: main N=8, saturating CNT_W=2, N=5.
// Expectations adapt to PRIO_ENC_RR_EN for the round-robin scenario.
module tb_prio_enc_queue;

  logic        clk;
  logic        rst;
  logic [7:0]  req;
  logic [7:0]  pend;
  logic [15:0] coal;
  logic [7:0]  req_s;
  logic [7:0]  pend_s;
  logic [1:0]  coal_s;
  logic [4:0]  req5;
  logic [4:0]  pend5;
  logic [15:0] coal5;

  int total;
  int bad;

  prio_enc_if #(.W(3)) bus  ();
  prio_enc_if #(.W(3)) bus_s();
  prio_enc_if #(.W(3)) bus5 ();

  prio_enc_queue #(.N(8), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req),
    .dn       (bus),
    .pend_o   (pend),
    .coal_cnt (coal)
  );

  prio_enc_queue #(.N(8), .CNT_W(2)) dut_s (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_s),
    .dn       (bus_s),
    .pend_o   (pend_s),
    .coal_cnt (coal_s)
  );

  prio_enc_queue #(.N(5), .CNT_W(16)) dut5 (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req5),
    .dn       (bus5),
    .pend_o   (pend5),
    .coal_cnt (coal5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    req_s = '0;
    req5 = '0;
    bus.out_ready = 1'b0;
    bus_s.out_ready = 1'b0;
    bus5.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 8'hFF;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00 || coal !== 16'h0) begin
      bad++;
      $display("FAIL reset_hold v=%b p=%h c=%h want 0/00/0",
               bus.out_valid, pend, coal);
    end
    tick();
    rst = 1'b0;
    req = '0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00 ||
        coal !== 16'h0 || bus.out_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_rel v=%b p=%h c=%h i=%0d want 0/00/0/0",
               bus.out_valid, pend, coal, bus.out_idx);
    end
  endtask

  task automatic test_priority();
    int exp_i[3] = '{2, 5, 7};
    do_reset();
    bus.out_ready = 1'b1;
    req = 8'b1010_0100;
    tick();
    req = '0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(exp_i[i])) begin
        bad++;
        $display("FAIL prio_%0d v=%b i=%0d want 1/%0d",
                 i, bus.out_valid, bus.out_idx, exp_i[i]);
      end
      tick();
    end
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00) begin
      bad++;
      $display("FAIL prio_empty v=%b p=%h want 0/00", bus.out_valid, pend);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    req = 8'h09;
    tick();
    req = '0;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0 || pend !== 8'h09) begin
        bad++;
        $display("FAIL bp_hold_%0d v=%b i=%0d p=%h want 1/0/09",
                 i, bus.out_valid, bus.out_idx, pend);
      end
      tick();
    end
    bus.out_ready = 1'b1;
    total++;
    if (bus.out_idx !== 3'd0) begin
      bad++;
      $display("FAIL bp_first i=%0d want 0", bus.out_idx);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd3 || pend !== 8'h08) begin
      bad++;
      $display("FAIL bp_second v=%b i=%0d p=%h want 1/3/08",
               bus.out_valid, bus.out_idx, pend);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00) begin
      bad++;
      $display("FAIL bp_empty v=%b p=%h want 0/00", bus.out_valid, pend);
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h01;
    tick();
    req = '0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd3 || pend !== 8'h09) begin
      bad++;
      $display("FAIL np_hold v=%b i=%0d p=%h want 1/3/09",
               bus.out_valid, bus.out_idx, pend);
    end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd0) begin
      bad++;
      $display("FAIL np_next v=%b i=%0d want 1/0", bus.out_valid, bus.out_idx);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL np_empty v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_coalesce();
    do_reset();
    req = 8'h10;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (coal !== 16'(i)) begin
        bad++;
        $display("FAIL coal_%0d c=%0d want %0d", i, coal, i);
      end
    end
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd4) begin
      bad++;
      $display("FAIL coal_slot v=%b i=%0d want 1/4", bus.out_valid, bus.out_idx);
    end
    bus.out_ready = 1'b1;
    tick();
    req = '0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd4 ||
        pend !== 8'h10 || coal !== 16'd3) begin
      bad++;
      $display("FAIL coal_reissue v=%b i=%0d p=%h c=%0d want 1/4/10/3",
               bus.out_valid, bus.out_idx, pend, coal);
    end
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00 || coal !== 16'd3) begin
      bad++;
      $display("FAIL coal_done v=%b p=%h c=%0d want 0/00/3",
               bus.out_valid, pend, coal);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = 8'h3C;
    tick();
    req = '0;
    total++;
    if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd2) begin
      bad++;
      $display("FAIL rm_pre v=%b i=%0d want 1/2", bus.out_valid, bus.out_idx);
    end
    rst = 1'b1;
    req = 8'hFF;
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00 ||
        coal !== 16'h0 || bus.out_idx !== 3'd0) begin
      bad++;
      $display("FAIL rm_rst v=%b p=%h c=%h i=%0d want 0/00/0/0",
               bus.out_valid, pend, coal, bus.out_idx);
    end
    rst = 1'b0;
    req = '0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0 || pend !== 8'h00) begin
      bad++;
      $display("FAIL rm_after v=%b p=%h want 0/00", bus.out_valid, pend);
    end
  endtask

  task automatic test_saturation();
    int exp_b[3] = '{0, 2, 3};
    do_reset();
    req_s = 8'h01;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (coal_s !== 2'((i < 3) ? i : 3)) begin
        bad++;
        $display("FAIL sat1_%0d c=%0d want %0d", i, coal_s, (i < 3) ? i : 3);
      end
    end
    do_reset();
    req_s = 8'h03;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (coal_s !== 2'(exp_b[i])) begin
        bad++;
        $display("FAIL sat2_%0d c=%0d want %0d", i, coal_s, exp_b[i]);
      end
    end
    req_s = '0;
  endtask

  task automatic test_rr();
    int e8;
    int e5;
    do_reset();
    req = 8'hFF;
    req5 = 5'h1F;
    bus.out_ready = 1'b1;
    bus5.out_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
`ifdef PRIO_ENC_RR_EN
      e8 = i % 8;
      e5 = i % 5;
`else
      e8 = 0;
      e5 = 0;
`endif
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(e8)) begin
        bad++;
        $display("FAIL rr8_%0d v=%b i=%0d want 1/%0d",
                 i, bus.out_valid, bus.out_idx, e8);
      end
      total++;
      if (bus5.out_valid !== 1'b1 || bus5.out_idx !== 3'(e5)) begin
        bad++;
        $display("FAIL rr5_%0d v=%b i=%0d want 1/%0d",
                 i, bus5.out_valid, bus5.out_idx, e5);
      end
      tick();
    end
    req = '0;
    req5 = '0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    req = '0;
    req_s = '0;
    req5 = '0;
    bus.out_ready = 1'b0;
    bus_s.out_ready = 1'b0;
    bus5.out_ready = 1'b0;
    test_reset();
    test_priority();
    test_backpressure();
    test_no_preempt();
    test_coalesce();
    test_reset_mid();
    test_saturation();
    test_rr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
